// File: rtl/fifo36_to_u32_gearbox_pkg.sv
// Shared widths, header magic and FSM encoding for the 36->32 bit dump gearbox.
package fifo36_to_u32_gearbox_pkg;

  localparam int FIFO_W = 36;
  localparam int OUT_W  = 32;
  localparam int ACC_W  = 68;
  localparam int FILL_W = 7;

  localparam logic [15:0] HDR_MAGIC_DEF = 16'hA5C3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Mask of the n low bits of an output word (n saturates at OUT_W).
  function automatic logic [OUT_W-1:0] low_mask(input logic [FILL_W-1:0] n);
    logic [OUT_W-1:0] m;
    m = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (i < int'(n)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo36_to_u32_gearbox_accum.sv
// Bit accumulator: appends 36-bit captures at the fill point, pops 32 bits from the bottom.
// Pop and capture may coincide; the capture lands at the post-pop fill.
module fifo36_to_u32_gearbox_accum
  import fifo36_to_u32_gearbox_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_vld,
  input  logic [FIFO_W-1:0] cap_dat,
  input  logic              pop,
  output logic [FILL_W-1:0] fill,
  output logic [OUT_W-1:0]  word,
  output logic [OUT_W-1:0]  pad_word
);

  logic [ACC_W-1:0]  acc_q, acc_d, acc_pop;
  logic [FILL_W-1:0] fill_q, fill_d, fill_pop;

  always_comb begin
    acc_pop  = acc_q;
    fill_pop = fill_q;
    if (pop) begin
      acc_pop  = acc_q >> OUT_W;
      fill_pop = (fill_q >= FILL_W'(OUT_W)) ? (fill_q - FILL_W'(OUT_W)) : '0;
    end
    acc_d  = acc_pop;
    fill_d = fill_pop;
    if (cap_vld) begin
      acc_d  = acc_pop | (ACC_W'(cap_dat) << fill_pop);
      fill_d = fill_pop + FILL_W'(FIFO_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

  assign fill     = fill_q;
  assign word     = acc_q[OUT_W-1:0];
  assign pad_word = acc_q[OUT_W-1:0] & low_mask(fill_q);

endmodule

// File: rtl/fifo36_to_u32_gearbox.sv
// Drains a 36-bit FIFO into a dense LSB-first 32-bit valid/ready stream, one header per frame.
// Reads only in RUN with at most one outstanding; output held stable under backpressure.
module fifo36_to_u32_gearbox
  import fifo36_to_u32_gearbox_pkg::*;
#(
  parameter int          FIFO_WIDTH = 36,
  parameter int          OUT_WIDTH  = 32,
  parameter logic [15:0] HDR_MAGIC  = HDR_MAGIC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_q,
  output logic                  fifo_rd_en,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);

  state_e            state_q, state_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              rd_pend_q;
  logic              pop;
  logic              pad_req;
  logic [FILL_W-1:0] fill;
  logic [OUT_W-1:0]  word, pad_word;

  fifo36_to_u32_gearbox_accum u_accum (
    .clk      (clk),
    .rst      (rst),
    .cap_vld  (rd_pend_q),
    .cap_dat  (fifo_q),
    .pop      (pop),
    .fill     (fill),
    .word     (word),
    .pad_word (pad_word)
  );

  // Read only while at most 32 bits are buffered so a capture never overflows 68 bits.
  assign fifo_rd_en = (state_q == ST_RUN) & ~fifo_empty & ~rd_pend_q & (fill <= FILL_W'(OUT_W));

  assign pad_req = (state_q == ST_FLUSH) & (fill != '0) & (fill < FILL_W'(OUT_W)) & ~rd_pend_q;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    out_valid   = 1'b0;
    out_data    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_HDR;
      end
      ST_HDR: begin
        out_valid = 1'b1;
        out_data  = {HDR_MAGIC, frame_cnt_q};
        if (out_ready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        out_valid = (fill >= FILL_W'(OUT_W));
        out_data  = word;
        if (flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        out_data = word;
        if (fill >= FILL_W'(OUT_W)) begin
          out_valid = 1'b1;
        end else if (pad_req) begin
          out_valid = 1'b1;
          out_data  = pad_word;
        end else if ((fill == '0) && !rd_pend_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pop = out_valid & out_ready & ((state_q == ST_RUN) | (state_q == ST_FLUSH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      rd_pend_q   <= fifo_rd_en;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo36_to_u32_gearbox.sv
// Directed bench for the 36->32 gearbox: behavioural FIFO model, output recorder, linear test steps.
module tb_fifo36_to_u32_gearbox;

  logic        clk = 1'b0;
  logic        rst, start, flush, fifo_empty, fifo_rd_en;
  logic [35:0] fifo_q;
  logic [31:0] out_data;
  logic        out_valid, out_ready, busy;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;

  logic [35:0] q[$];
  logic [31:0] got[$];

  always #5 clk = ~clk;

  fifo36_to_u32_gearbox dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO read port: data appears one cycle after the strobe, empty tracks the queue.
  initial begin : fifo_model
    logic take;
    fifo_q     = '0;
    fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      take = fifo_rd_en;
      @(posedge clk);
      #1;
      if (take === 1'b1) begin
        rd_cnt++;
        chk("fifo_read_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) fifo_q = q.pop_front();
      end
      fifo_empty = (q.size() == 0);
    end
  end

  initial begin : out_monitor
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_data);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin
      tick();
      k++;
    end
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_got(input int n, input string tag);
    int k = 0;
    while (got.size() < n && k < 300) begin
      tick();
      k++;
    end
    chk({tag, "_got"}, 64'(got.size() >= n), 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while (q.size() != 0 && k < 500) begin
      tick();
      k++;
    end
    chk({tag, "_drain"}, 64'(q.size()), 64'd0);
    tick(4);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_cnt"}, 64'(frame_cnt), 64'd0);
  endtask

  task automatic check_ones_frame(input string tag, input logic [31:0] hdr);
    chk({tag, "_nwords"}, 64'(got.size()), 64'd10);
    chk({tag, "_hdr"}, 64'(got[0]), 64'(hdr));
    for (int i = 1; i < 10; i++) chk({tag, "_word"}, 64'(got[i]), 64'hFFFF_FFFF);
  endtask

  initial begin : main
    int rd0;
    int seen;
    int k;
    rst       = 1'b1;
    start     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // 8 all-ones words pack into exactly 9 output words, no pad
    got.delete();
    for (int i = 0; i < 8; i++) q.push_back(36'hF_FFFF_FFFF);
    pulse_start();
    wait_drain("t1");
    pulse_flush();
    wait_idle("t1");
    check_ones_frame("t1", 32'hA5C3_0000);
    chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);

    // single word leaves a 4-bit residue that is zero-padded on flush
    got.delete();
    q.push_back(36'h9_1234_5678);
    pulse_start();
    wait_drain("t2");
    pulse_flush();
    wait_idle("t2");
    chk("t2_nwords", 64'(got.size()), 64'd3);
    chk("t2_hdr", 64'(got[0]), 64'hA5C3_0001);
    chk("t2_w0", 64'(got[1]), 64'h1234_5678);
    chk("t2_pad", 64'(got[2]), 64'h0000_0009);

    // back-to-back header-only frames with the FIFO empty throughout
    do_reset();
    got.delete();
    rd0 = rd_cnt;
    pulse_start();
    wait_got(1, "t3a");
    tick(3);
    chk("t3_busy_run", 64'(busy), 64'd1);
    chk("t3_no_read", 64'(fifo_rd_en), 64'd0);
    pulse_flush();
    wait_idle("t3a");
    chk("t3_only_hdr", 64'(got.size()), 64'd1);
    pulse_start();
    wait_got(2, "t3b");
    pulse_flush();
    wait_idle("t3b");
    chk("t3_nwords", 64'(got.size()), 64'd2);
    chk("t3_hdr0", 64'(got[0]), 64'hA5C3_0000);
    chk("t3_hdr1", 64'(got[1]), 64'hA5C3_0001);
    chk("t3_frame_cnt", 64'(frame_cnt), 64'd2);
    chk("t3_read_count", 64'(rd_cnt - rd0), 64'd0);

    // backpressure after the first data word
    do_reset();
    got.delete();
    for (int i = 0; i < 8; i++) q.push_back(36'hF_FFFF_FFFF);
    pulse_start();
    wait_got(2, "t4");
    out_ready = 1'b0;
    tick(3);
    rd0 = rd_cnt;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      chk("t4_hold_data", 64'(out_data), 64'hFFFF_FFFF);
      chk("t4_hold_no_read", 64'(fifo_rd_en), 64'd0);
    end
    chk("t4_stall_reads", 64'(rd_cnt - rd0), 64'd0);
    chk("t4_fifo_pending", 64'(q.size() != 0), 64'd1);
    out_ready = 1'b1;
    wait_drain("t4");
    pulse_flush();
    wait_idle("t4");
    check_ones_frame("t4", 32'hA5C3_0000);

    // reset while a FIFO read is in flight
    do_reset();
    got.delete();
    q.push_back(36'h1_0000_0001);
    q.push_back(36'h2_0000_0002);
    q.push_back(36'h3_0000_0003);
    pulse_start();
    seen = 0;
    k = 0;
    while (seen < 2 && k < 100) begin
      tick();
      if (fifo_rd_en === 1'b1) seen++;
      k++;
    end
    chk("t6_reads_seen", 64'(seen), 64'd2);
    tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("t6_rst");
    rst = 1'b0;
    q.delete();
    tick(2);
    got.delete();
    pulse_start();
    wait_got(1, "t6");
    chk("t6_hdr", 64'(got[0]), 64'hA5C3_0000);
    pulse_flush();
    wait_idle("t6");
    chk("t6_nwords", 64'(got.size()), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
